// File: rtl/t_latch_pkg.sv
// Shared types and helpers for the T-latch toggle scheduler.
package t_latch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Width of the settle counter; SETTLE must not exceed 2**SETTLE_CW.
    localparam int SETTLE_CW = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/t_latch_rr_arb.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
module t_latch_rr_arb
    import t_latch_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    logic [PW-1:0] r;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        r       = '0;
        for (int i = 0; i < NREQ; i++) begin
            r = PW'((int'(ptr) + i) % NREQ);
            if (!any && req[r]) begin
                win_oh[r] = 1'b1;
                win_idx   = r;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t_latch_toggle_sched.sv
// Round-robin scheduler issuing single-cycle T=1 strobes to a bank of T latches.
// Optional toggle verification through q_i is enabled by TLATCH_TOGGLE_CHECK_EN.
module t_latch_toggle_sched
    import t_latch_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NCELL  = 8,
    parameter int SETTLE = 1,
    localparam int IDXW  = idx_width(NCELL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 ok,
    output logic [NCELL-1:0]     en_o,
    output logic                 t_o,
    input  logic [NCELL-1:0]     q_i,
    output logic                 busy
);

    localparam int PW = idx_width(NREQ);

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          win_idx;
    logic [NREQ-1:0]        win_oh;
    logic [NREQ-1:0]        cur_w;
    logic                   any_req;
    logic [IDXW-1:0]        sel_idx;
    logic [IDXW-1:0]        cur_idx;
    logic                   sel_in_range;
    logic [SETTLE_CW-1:0]   cnt;
    logic                   toggled;

    t_latch_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any_req)
    );

    assign sel_idx      = req_idx[int'(win_idx)*IDXW +: IDXW];
    assign sel_in_range = int'(sel_idx) < NCELL;

`ifdef TLATCH_TOGGLE_CHECK_EN
    logic pre;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= 1'b0;
        end else if (state == IDLE && any_req && sel_in_range) begin
            pre <= q_i[sel_idx];
        end
    end

    assign toggled = q_i[cur_idx] != pre;
`else
    logic unused_q;
    assign unused_q = ^q_i;
    assign toggled  = 1'b1;
`endif

    // An out-of-range index enters CHECK with done still low; the first CHECK
    // cycle then raises done so it never coincides with gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            ok      <= 1'b0;
            en_o    <= '0;
            t_o     <= 1'b0;
            busy    <= 1'b0;
            rr_ptr  <= '0;
            cur_w   <= '0;
            cur_idx <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= win_oh;
                        cur_w   <= win_oh;
                        cur_idx <= sel_idx;
                        busy    <= 1'b1;
                        rr_ptr  <= PW'((int'(win_idx) + 1) % NREQ);
                        if (sel_in_range) begin
                            en_o  <= NCELL'(1) << sel_idx;
                            t_o   <= 1'b1;
                            state <= PULSE;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                PULSE: begin
                    gnt   <= '0;
                    en_o  <= '0;
                    t_o   <= 1'b0;
                    cnt   <= SETTLE_CW'(SETTLE - 1);
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        done  <= cur_w;
                        ok    <= toggled;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (done == '0) begin
                        gnt  <= '0;
                        done <= cur_w;
                        ok   <= 1'b0;
                    end else begin
                        done  <= '0;
                        ok    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t_latch_toggle_sched.sv
// Scoreboard bench for t_latch_toggle_sched (NREQ=4, NCELL=6, SETTLE=1).
module tb_t_latch_toggle_sched;

    localparam int NREQ  = 4;
    localparam int NCELL = 6;
    localparam int IDXW  = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 ok;
    logic [NCELL-1:0]     en_o;
    logic                 t_o;
    logic [NCELL-1:0]     q;
    logic                 busy;
    logic                 ignore_strobe;

    logic [NREQ-1:0] exp_gnt_q[$];
    logic [NREQ:0]   exp_done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    t_latch_toggle_sched #(.NREQ(NREQ), .NCELL(NCELL), .SETTLE(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_idx (req_idx),
        .gnt     (gnt),
        .done    (done),
        .ok      (ok),
        .en_o    (en_o),
        .t_o     (t_o),
        .q_i     (q),
        .busy    (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // T latch bank model: a strobe with T=1 flips the addressed cell
    initial q = '0;
    always @(posedge clk) begin
        if (!ignore_strobe && t_o) q <= q ^ en_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [NREQ:0] e;
        check("en_onehot", 32'($countones(en_o) <= 1), 32'd1);
        check("t_o_vs_en", 32'(t_o), 32'(|en_o));
        check("gnt_done_excl", 32'(|(gnt & done)), 32'd0);
        if (gnt != '0) begin
            if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
            else check("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
        end
        if (done != '0) begin
            if (exp_done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else begin
                e = exp_done_q.pop_front();
                check("done_who", 32'(done), 32'(e[NREQ:1]));
                check("done_ok", 32'(ok), 32'(e[0]));
            end
        end
    end

    // driver tasks
    task automatic set_idx(input int r, input logic [IDXW-1:0] v);
        req_idx[r*IDXW +: IDXW] = v;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int g;
        logic exp_ok5;
        rst_n = 1'b0;
        req = 4'b1111;
        req_idx = '0;
        ignore_strobe = 1'b0;
        for (int r = 0; r < NREQ; r++) set_idx(r, IDXW'(r));

        // reset with all requests pending
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ok", 32'(ok), 32'd0);
        check("rst_en", 32'(en_o), 32'd0);
        check("rst_t", 32'(t_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // fairness: continuous 4'b1111 -> 0,1,2,3,0
        foreach (exp_gnt_q[i]) ;
        exp_gnt_q.push_back(4'b0001); exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0100); exp_gnt_q.push_back(4'b1000);
        exp_gnt_q.push_back(4'b0001);
        exp_done_q.push_back({4'b0001, 1'b1}); exp_done_q.push_back({4'b0010, 1'b1});
        exp_done_q.push_back({4'b0100, 1'b1}); exp_done_q.push_back({4'b1000, 1'b1});
        exp_done_q.push_back({4'b0001, 1'b1});
        rst_n = 1'b1;
        g = 0;
        for (int i = 0; i < 100 && g < 5; i++) begin
            @(negedge clk);
            if (gnt != '0) g++;
        end
        check("fair_grants", 32'(g), 32'd5);
        req = '0;
        wait_idle();

        // single request: r2 -> cell 5
        set_idx(2, 3'd5);
        req = 4'b0100;
        exp_gnt_q.push_back(4'b0100);
        exp_done_q.push_back({4'b0100, 1'b1});
        @(negedge clk);
        check("single_gnt_c1", 32'(gnt), 32'h4);
        check("single_en_c1", 32'(en_o), 32'h20);
        check("single_t_c1", 32'(t_o), 32'd1);
        req = '0;
        @(negedge clk);
        check("single_en_c2", 32'(en_o), 32'h0);
        check("single_done_c2", 32'(done), 32'h0);
        @(negedge clk);
        check("single_done_c3", 32'(done), 32'h4);
        check("single_q5", 32'(q[5]), 32'd1);
        wait_idle();

        // out-of-range cell: r1 -> idx 7 with NCELL=6
        set_idx(1, 3'd7);
        req = 4'b0010;
        exp_gnt_q.push_back(4'b0010);
        exp_done_q.push_back({4'b0010, 1'b0});
        @(negedge clk);
        check("bad_gnt_c1", 32'(gnt), 32'h2);
        check("bad_en_c1", 32'(en_o), 32'h0);
        req = '0;
        @(negedge clk);
        check("bad_en_c2", 32'(en_o), 32'h0);
        check("bad_done_c2", 32'(done), 32'h2);
        wait_idle();

        // latch ignores the strobe
`ifdef TLATCH_TOGGLE_CHECK_EN
        exp_ok5 = 1'b0;
`else
        exp_ok5 = 1'b1;
`endif
        ignore_strobe = 1'b1;
        set_idx(3, 3'd2);
        req = 4'b1000;
        exp_gnt_q.push_back(4'b1000);
        exp_done_q.push_back({4'b1000, exp_ok5});
        @(negedge clk);
        req = '0;
        check("stuck_en_c1", 32'(en_o), 32'h4);
        wait_idle();
        ignore_strobe = 1'b0;

        // reset mid-PULSE: r2 -> cell 4, then rr must restart at 0
        set_idx(2, 3'd4);
        req = 4'b0100;
        exp_gnt_q.push_back(4'b0100);
        @(negedge clk);
        check("midrst_en_pre", 32'(en_o), 32'h10);
        #1;
        rst_n = 1'b0;
        req = '0;
        #1;
        check("midrst_en", 32'(en_o), 32'h0);
        check("midrst_t", 32'(t_o), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_q4", 32'(q[4]), 32'd0);
        rst_n = 1'b1;
        req = 4'b1111;
        exp_gnt_q.push_back(4'b0001);
        exp_done_q.push_back({4'b0001, 1'b1});
        @(negedge clk);
        check("midrst_rr0", 32'(gnt), 32'h1);
        req = '0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
